// File: rtl/stroke_rasterizer.sv
// Stamps a filled disc of radius Rc around each accepted control point into the frame buffer,
// one candidate pixel per cycle in raster order, and pulses stroke_done after a "last" point.
module stroke_rasterizer #(
   parameter int IMG_W  = 640,
   parameter int IMG_H  = 480,
   parameter int R_MAX  = 8,
   parameter int ADDR_W = 19
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_pt_valid,
   output logic              o_pt_ready,
   input  logic [9:0]        i_pt_x,
   input  logic [9:0]        i_pt_y,
   input  logic              i_pt_last,
   input  logic [3:0]        i_R,
   input  logic [23:0]       i_color,
   output logic              o_wr_valid,
   input  logic              i_wr_ready,
   output logic [ADDR_W-1:0] o_wr_addr,
   output logic [23:0]       o_wr_data,
   output logic              o_stroke_done
);
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_SCAN = 2'd1, S_DONE = 2'd2} state_t;

   localparam logic signed [11:0] W_S    = 12'(IMG_W);
   localparam logic signed [11:0] H_S    = 12'(IMG_H);
   localparam logic [3:0]         RMAX_C = 4'(R_MAX);

   function automatic logic signed [11:0] coord_f(input logic [9:0] c, input logic signed [4:0] d);
      return $signed({2'b00, c}) + $signed({{7{d[4]}}, d});
   endfunction

   function automatic logic [7:0] sq_f(input logic signed [4:0] v);
      logic [4:0] m;
      m = v[4] ? (5'd0 - v) : v;
      return {3'd0, m} * {3'd0, m};
   endfunction

   function automatic logic hit_f(input logic [9:0] x, input logic [9:0] y,
                                  input logic signed [4:0] dx, input logic signed [4:0] dy,
                                  input logic [3:0] rc);
      logic signed [11:0] px;
      logic signed [11:0] py;
      logic [8:0]         d2;
      logic [8:0]         r2;
      px = coord_f(x, dx);
      py = coord_f(y, dy);
      d2 = {1'b0, sq_f(dx)} + {1'b0, sq_f(dy)};
      r2 = {1'b0, {4'd0, rc} * {4'd0, rc}};
      return (d2 <= r2) && (px >= 12'sd0) && (px < W_S) && (py >= 12'sd0) && (py < H_S);
   endfunction

   // Only meaningful for in-canvas candidates, where both coordinates are non-negative.
   function automatic logic [ADDR_W-1:0] addr_f(input logic [9:0] x, input logic [9:0] y,
                                                input logic signed [4:0] dx, input logic signed [4:0] dy);
      logic signed [11:0] px;
      logic signed [11:0] py;
      px = coord_f(x, dx);
      py = coord_f(y, dy);
      return ADDR_W'(py[9:0]) * ADDR_W'(IMG_W) + ADDR_W'(px[9:0]);
   endfunction

   state_t             state_q;
   logic [9:0]         x_q, y_q;
   logic [3:0]         rc_q;
   logic               last_q;
   logic [23:0]        color_q;
   logic signed [4:0]  dx_q, dy_q;
   logic               wr_valid_q, ready_q, done_q;
   logic [ADDR_W-1:0]  addr_q;

   logic [3:0]         rc_in_s, crc_s;
   logic               accept_s, advance_s, at_end_s, hit_s;
   logic signed [4:0]  rc_s, ndx_s, ndy_s, cdx_s, cdy_s;
   logic [9:0]         cx_s, cy_s;
   logic [ADDR_W-1:0]  addr_s;

   // The candidate fed to the evaluator is the first one of a new point on accept,
   // otherwise the successor of the current one; its result is registered on the move.
   always_comb begin
      rc_in_s   = (i_R > RMAX_C) ? RMAX_C : i_R;
      accept_s  = ready_q && i_pt_valid;
      advance_s = (state_q == S_SCAN) && (!wr_valid_q || i_wr_ready);
      rc_s      = $signed({1'b0, rc_q});
      at_end_s  = (dx_q == rc_s) && (dy_q == rc_s);
      if (dx_q == rc_s) begin
         ndx_s = 5'sd0 - rc_s;
         ndy_s = dy_q + 5'sd1;
      end else begin
         ndx_s = dx_q + 5'sd1;
         ndy_s = dy_q;
      end
      if (accept_s) begin
         cx_s  = i_pt_x;
         cy_s  = i_pt_y;
         crc_s = rc_in_s;
         cdx_s = 5'sd0 - $signed({1'b0, rc_in_s});
         cdy_s = 5'sd0 - $signed({1'b0, rc_in_s});
      end else begin
         cx_s  = x_q;
         cy_s  = y_q;
         crc_s = rc_q;
         cdx_s = ndx_s;
         cdy_s = ndy_s;
      end
      hit_s  = hit_f(cx_s, cy_s, cdx_s, cdy_s, crc_s);
      addr_s = addr_f(cx_s, cy_s, cdx_s, cdy_s);
   end

   // Control FSM with all outputs held in registers.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q    <= S_IDLE;
         x_q        <= 10'd0;
         y_q        <= 10'd0;
         rc_q       <= 4'd0;
         last_q     <= 1'b0;
         color_q    <= 24'd0;
         dx_q       <= 5'sd0;
         dy_q       <= 5'sd0;
         wr_valid_q <= 1'b0;
         ready_q    <= 1'b1;
         done_q     <= 1'b0;
         addr_q     <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (accept_s) begin
                  x_q        <= i_pt_x;
                  y_q        <= i_pt_y;
                  rc_q       <= rc_in_s;
                  last_q     <= i_pt_last;
                  color_q    <= i_color;
                  dx_q       <= cdx_s;
                  dy_q       <= cdy_s;
                  wr_valid_q <= hit_s;
                  addr_q     <= addr_s;
                  ready_q    <= 1'b0;
                  state_q    <= S_SCAN;
               end
            end
            S_SCAN: begin
               if (advance_s) begin
                  if (at_end_s) begin
                     wr_valid_q <= 1'b0;
                     if (last_q) begin
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                     end else begin
                        ready_q <= 1'b1;
                        state_q <= S_IDLE;
                     end
                  end else begin
                     dx_q       <= ndx_s;
                     dy_q       <= ndy_s;
                     wr_valid_q <= hit_s;
                     addr_q     <= addr_s;
                  end
               end
            end
            S_DONE: begin
               done_q  <= 1'b0;
               ready_q <= 1'b1;
               state_q <= S_IDLE;
            end
            default: begin
               wr_valid_q <= 1'b0;
               done_q     <= 1'b0;
               ready_q    <= 1'b1;
               state_q    <= S_IDLE;
            end
         endcase
      end
   end

   assign o_pt_ready    = ready_q;
   assign o_wr_valid    = wr_valid_q;
   assign o_wr_addr     = addr_q;
   assign o_wr_data     = color_q;
   assign o_stroke_done = done_q;
endmodule

// File: tb/tb_stroke_rasterizer.sv
// Directed bench for stroke_rasterizer: single pixel, small discs, canvas clipping,
// random back-pressure, radius clamping with stroke_done timing, and reset mid-scan.
module tb_stroke_rasterizer;
   logic        i_clk = 1'b0;
   logic        i_rst_n = 1'b0;
   logic        i_pt_valid = 1'b0;
   logic        o_pt_ready;
   logic [9:0]  i_pt_x = 10'd0;
   logic [9:0]  i_pt_y = 10'd0;
   logic        i_pt_last = 1'b0;
   logic [3:0]  i_R = 4'd0;
   logic [23:0] i_color = 24'd0;
   logic        o_wr_valid;
   logic        i_wr_ready = 1'b1;
   logic [18:0] o_wr_addr;
   logic [23:0] o_wr_data;
   logic        o_stroke_done;

   stroke_rasterizer dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_pt_valid(i_pt_valid), .o_pt_ready(o_pt_ready),
      .i_pt_x(i_pt_x), .i_pt_y(i_pt_y), .i_pt_last(i_pt_last), .i_R(i_R), .i_color(i_color),
      .o_wr_valid(o_wr_valid), .i_wr_ready(i_wr_ready), .o_wr_addr(o_wr_addr),
      .o_wr_data(o_wr_data), .o_stroke_done(o_stroke_done)
   );

   always #5 i_clk = ~i_clk;

   int          checks = 0;
   int          errors = 0;
   logic [18:0] wq[$];
   logic [23:0] wdq[$];
   int          exp_q[$];
   int          done_cnt = 0;
   int          busy = 0;
   logic        prev_stall = 1'b0;
   logic [18:0] prev_addr = 19'd0;
   logic [23:0] prev_data = 24'd0;

   // Monitor: accepted writes, done pulses, busy cycles, and hold-while-stalled.
   always @(posedge i_clk) begin
      if (prev_stall) begin
         checks++;
         assert (o_wr_valid === 1'b1 && o_wr_addr === prev_addr && o_wr_data === prev_data) else begin
            errors++;
            $error("FAIL stall_hold: got valid %b addr %0d data %h, expected valid 1 addr %0d data %h",
                   o_wr_valid, o_wr_addr, o_wr_data, prev_addr, prev_data);
         end
      end
      prev_stall = o_wr_valid && !i_wr_ready;
      prev_addr  = o_wr_addr;
      prev_data  = o_wr_data;
      if (o_wr_valid && i_wr_ready) begin
         wq.push_back(o_wr_addr);
         wdq.push_back(o_wr_data);
      end
      if (o_stroke_done) done_cnt++;
      if (!o_pt_ready) busy++;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
      end
   endtask

   task automatic clear_log();
      wq.delete();
      wdq.delete();
      exp_q.delete();
      done_cnt = 0;
      busy = 0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (o_pt_ready !== 1'b1 && n < 5000) begin
         @(negedge i_clk);
         n++;
      end
      chk("idle_reached", 32'(o_pt_ready), 32'd1);
   endtask

   // Returns at the falling edge of the first cycle after the accept edge.
   task automatic send(input logic [9:0] x, input logic [9:0] y, input logic [3:0] r,
                       input logic last, input logic [23:0] c);
      wait_idle();
      i_pt_x = x; i_pt_y = y; i_R = r; i_pt_last = last; i_color = c;
      i_pt_valid = 1'b1;
      @(posedge i_clk);
      @(negedge i_clk);
      i_pt_valid = 1'b0;
   endtask

   task automatic add_disc(input int x, input int y, input int r);
      for (int dy = -r; dy <= r; dy++)
         for (int dx = -r; dx <= r; dx++)
            if (dx * dx + dy * dy <= r * r && x + dx >= 0 && x + dx < 640 && y + dy >= 0 && y + dy < 480)
               exp_q.push_back((y + dy) * 640 + (x + dx));
   endtask

   task automatic chk_writes(input string tag);
      chk({tag, "_count"}, 32'(wq.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < wq.size(); i++)
         chk({tag, "_addr"}, 32'(wq[i]), 32'(exp_q[i]));
   endtask

   initial begin
      int bad;
      repeat (2) @(negedge i_clk);
      chk("rst_ready", 32'(o_pt_ready), 32'd1);
      chk("rst_valid", 32'(o_wr_valid), 32'd0);
      chk("rst_done", 32'(o_stroke_done), 32'd0);
      chk("rst_addr", 32'(o_wr_addr), 32'd0);
      chk("rst_data", 32'(o_wr_data), 32'd0);
      i_rst_n = 1'b1;
      @(negedge i_clk);

      // Single pixel
      clear_log();
      send(10'd10, 10'd20, 4'd0, 1'b0, 24'hABCDEF);
      chk("t1_valid", 32'(o_wr_valid), 32'd1);
      chk("t1_addr", 32'(o_wr_addr), 32'd12810);
      chk("t1_data", 32'(o_wr_data), 32'hABCDEF);
      chk("t1_busy", 32'(o_pt_ready), 32'd0);
      @(negedge i_clk);
      chk("t1_ready_back", 32'(o_pt_ready), 32'd1);
      chk("t1_valid_off", 32'(o_wr_valid), 32'd0);
      repeat (2) @(negedge i_clk);
      chk("t1_writes", 32'(wq.size()), 32'd1);
      chk("t1_no_done", 32'(done_cnt), 32'd0);

      // R=1 interior disc
      clear_log();
      send(10'd100, 10'd100, 4'd1, 1'b0, 24'h123456);
      wait_idle();
      exp_q = '{63460, 64099, 64100, 64101, 64740};
      chk_writes("t2");
      chk("t2_cycles", 32'(busy), 32'd9);

      // R=2 clipped at the origin corner
      clear_log();
      send(10'd0, 10'd0, 4'd2, 1'b0, 24'h00FF00);
      wait_idle();
      exp_q = '{0, 1, 2, 640, 641, 1280};
      chk_writes("t3");
      chk("t3_cycles", 32'(busy), 32'd25);

      // R=3 with random back-pressure
      clear_log();
      send(10'd320, 10'd240, 4'd3, 1'b0, 24'h5A5A5A);
      for (int c = 0; c < 2000 && o_pt_ready !== 1'b1; c++) begin
         i_wr_ready = 1'($urandom_range(0, 1));
         @(negedge i_clk);
      end
      wait_idle();
      i_wr_ready = 1'b1;
      add_disc(320, 240, 3);
      chk_writes("t4");
      bad = 0;
      foreach (wdq[i]) if (wdq[i] !== 24'h5A5A5A) bad++;
      chk("t4_data", 32'(bad), 32'd0);

      // Three points with clamped radius, last on the third
      clear_log();
      send(10'd200, 10'd200, 4'd12, 1'b0, 24'h0F0F0F);
      send(10'd300, 10'd300, 4'd12, 1'b0, 24'h0F0F0F);
      send(10'd400, 10'd200, 4'd12, 1'b1, 24'h0F0F0F);
      repeat (289) @(negedge i_clk);
      chk("t5_done_pulse", 32'(o_stroke_done), 32'd1);
      chk("t5_done_busy", 32'(o_pt_ready), 32'd0);
      @(negedge i_clk);
      chk("t5_done_end", 32'(o_stroke_done), 32'd0);
      chk("t5_ready_back", 32'(o_pt_ready), 32'd1);
      add_disc(200, 200, 8);
      add_disc(300, 300, 8);
      add_disc(400, 200, 8);
      chk_writes("t5");
      chk("t5_cycles", 32'(busy), 32'd868);
      chk("t5_done_count", 32'(done_cnt), 32'd1);
      bad = 0;
      foreach (wdq[i]) if (wdq[i] !== 24'h0F0F0F) bad++;
      chk("t5_data", 32'(bad), 32'd0);

      // Reset during a scan
      clear_log();
      send(10'd320, 10'd240, 4'd3, 1'b1, 24'hC0FFEE);
      repeat (3) @(negedge i_clk);
      chk("t6_pre_valid", 32'(o_wr_valid), 32'd1);
      #2 i_rst_n = 1'b0;
      #1;
      chk("t6_async_valid", 32'(o_wr_valid), 32'd0);
      chk("t6_async_ready", 32'(o_pt_ready), 32'd1);
      @(negedge i_clk);
      clear_log();
      @(negedge i_clk);
      i_rst_n = 1'b1;
      repeat (80) @(negedge i_clk);
      chk("t6_no_writes", 32'(wq.size()), 32'd0);
      chk("t6_no_done", 32'(done_cnt), 32'd0);
      chk("t6_ready", 32'(o_pt_ready), 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
